// File: rtl/uart_cmd_master_pkg.sv
// Shared opcodes, frame lengths and FSM state type for the HyperRAM test-harness
// serial command master.
package uart_cmd_master_pkg;

  localparam logic [7:0] OP_ADDR     = 8'h01;
  localparam logic [7:0] OP_LOAD     = 8'h02;
  localparam logic [7:0] OP_WRITE    = 8'h03;
  localparam logic [7:0] OP_READ     = 8'h04;
  localparam logic [7:0] OP_READ_REQ = 8'h05;
  localparam logic [7:0] OP_COUNT    = 8'h06;
  localparam logic [7:0] OP_CONST    = 8'h07;

  localparam logic [2:0] CMD_FRAME_BYTES = 3'd5;
  localparam logic [2:0] RSP_FRAME_BYTES = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_ISSUE = 3'd1,
    ST_TX_WAIT  = 3'd2,
    ST_RX       = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Reply bytes arrive MSB first, so each new byte enters at the bottom.
  function automatic logic [39:0] shift_in_byte(input logic [39:0] word,
                                                input logic [7:0]  new_byte);
    return {word[31:0], new_byte};
  endfunction

endpackage

// File: rtl/uart_cmd_master_timeout.sv
// Reply watchdog for uart_cmd_master: counts idle RX cycles and flags expiry.
// Only instantiated when CMD_MASTER_TIMEOUT_EN is defined.
module cmd_timeout_ctr #(
  parameter logic [23:0] LIMIT = 24'd1_200_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  logic [23:0] cnt_q, cnt_d;

  // Next count: clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 24'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 24'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == (LIMIT - 24'd1));

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side 5-byte command initiator driving external uart_tx/uart_rx.
// Optional reply timeout is built only when CMD_MASTER_TIMEOUT_EN is defined.
module uart_cmd_master
  import uart_cmd_master_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data
);

  state_e      state_q, state_d;
  logic [39:0] shift_q, shift_d;
  logic [39:0] reply_q, reply_d;
  logic [2:0]  txcnt_q, txcnt_d;
  logic [2:0]  rxcnt_q, rxcnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timeout_s;
  logic        to_clear_s;

`ifdef CMD_MASTER_TIMEOUT_EN
  cmd_timeout_ctr #(
    .LIMIT    (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (to_clear_s),
    .en_i     (state_q == ST_RX),
    .expire_o (timeout_s)
  );
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^{TIMEOUT_CYCLES, to_clear_s};
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; outputs are derived from state_d so they register cleanly.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    reply_d     = reply_q;
    txcnt_d     = txcnt_q;
    rxcnt_d     = rxcnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    to_clear_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          shift_d = {cmd_op, cmd_data};
          txcnt_d = 3'd0;
          state_d = ST_TX_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TX_ISSUE: begin
        if (!tx_ready) begin
          shift_d = {shift_q[31:0], 8'h00};
          txcnt_d = txcnt_q + 3'd1;
          state_d = ST_TX_WAIT;
        end else begin
          state_d = ST_TX_ISSUE;
        end
      end

      ST_TX_WAIT: begin
        if (tx_ready) begin
          if (txcnt_q == CMD_FRAME_BYTES) begin
            state_d    = ST_RX;
            to_clear_s = 1'b1;
            // A reply byte landing on the handover cycle must not be dropped.
            if (rx_rcv) begin
              reply_d = {32'd0, rx_data};
              rxcnt_d = 3'd1;
            end else begin
              reply_d = 40'd0;
              rxcnt_d = 3'd0;
            end
          end else begin
            state_d = ST_TX_ISSUE;
          end
        end else begin
          state_d = ST_TX_WAIT;
        end
      end

      ST_RX: begin
        if (rx_rcv) begin
          reply_d    = shift_in_byte(reply_q, rx_data);
          rxcnt_d    = rxcnt_q + 3'd1;
          to_clear_s = 1'b1;
          if (rxcnt_q == (RSP_FRAME_BYTES - 3'd1)) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = reply_d[39:8];
            rsp_err_d   = (reply_d[7:0] != 8'h00);
          end else begin
            state_d = ST_RX;
          end
        end else if (timeout_s) begin
          // Fewer than 5 bytes arrived, so the partial reply is already right-aligned.
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = reply_q[31:0];
          rsp_err_d   = 1'b1;
        end else begin
          state_d = ST_RX;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    tx_start_d  = (state_d == ST_TX_ISSUE);
    if (state_d == ST_TX_ISSUE) begin
      tx_data_d = shift_d[39:32];
    end else begin
      tx_data_d = tx_data_q;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= 40'd0;
      reply_q     <= 40'd0;
      txcnt_q     <= 3'd0;
      rxcnt_q     <= 3'd0;
      cmd_ready_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      reply_q     <= reply_d;
      txcnt_q     <= txcnt_d;
      rxcnt_q     <= rxcnt_d;
      cmd_ready_q <= cmd_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master with a behavioural uart_tx and scoreboards
// for transmitted bytes and responses.
module tb_uart_cmd_master;
  import uart_cmd_master_pkg::*;

`ifdef CMD_MASTER_TIMEOUT_EN
  localparam logic [23:0] TO_CYC = 24'd100;
`else
  localparam logic [23:0] TO_CYC = 24'd1_200_000;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = 8'h00;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        rx_rcv = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  int   n_tests = 0;
  int   n_fail = 0;
  int   tx_seen = 0;
  logic tx_busy = 1'b0;
  int   rsp_seen = 0;
  int   cyc = 0;
  int   rsp_cyc = 0;
  int   last_rx_cyc = 0;
  int   tgt = 0;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];

  uart_cmd_master #(
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_rcv    (rx_rcv),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // uart_tx model: accepts on start&&ready, drops ready 0 or 1 cycles later, busy 3 cycles.
  initial begin : tx_model
    logic [7:0] got;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && tx_ready) begin
        got = tx_data;
        tx_seen++;
        tx_busy = 1'b1;
        check("tx_byte_expected", {31'd0, exp_tx.size() > 0}, 32'd1);
        if (exp_tx.size() > 0) begin
          e = exp_tx.pop_front();
          check("tx_byte", {24'd0, got}, {24'd0, e});
        end
        if (tx_seen % 2 == 1) @(negedge clk);
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid and checks pulse width.
  initial begin : rsp_monitor
    logic prev_valid;
    rsp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_valid) begin
        check("rsp_valid_one_cycle", {31'd0, rsp_valid}, 32'd0);
      end
      if (rsp_valid === 1'b1) begin
        rsp_seen++;
        rsp_cyc = cyc;
        check("rsp_expected", {31'd0, exp_rsp.size() > 0}, 32'd1);
        if (exp_rsp.size() > 0) begin
          e = exp_rsp.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
      prev_valid = (rsp_valid === 1'b1);
    end
  end

  task automatic push_tx(input logic [7:0] op, input logic [31:0] data);
    exp_tx.push_back(op);
    exp_tx.push_back(data[31:24]);
    exp_tx.push_back(data[23:16]);
    exp_tx.push_back(data[15:8]);
    exp_tx.push_back(data[7:0]);
  endtask

  task automatic wait_ready_idle();
    int k = 0;
    while ((cmd_ready !== 1'b1 || tx_busy) && k < 200) begin
      step();
      k++;
    end
    check("wait_cmd_ready_bound", {31'd0, k < 200}, 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] data);
    push_tx(op, data);
    wait_ready_idle();
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("cmd_ready_fall", {31'd0, cmd_ready}, 32'd0);
    check("tx_start_rise", {31'd0, tx_start}, 32'd1);
  endtask

  task automatic wait_tx(input int target);
    int k = 0;
    while ((tx_seen < target || tx_busy) && k < 500) begin
      step();
      k++;
    end
    check("wait_tx_bound", {31'd0, k < 500}, 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_seen < n && k < 2000) begin
      step();
      k++;
    end
    check("wait_rsp_bound", {31'd0, k < 2000}, 32'd1);
  endtask

  task automatic send_reply(input logic [39:0] reply, input int n, input bit same_cycle);
    if (!same_cycle) step(3);
    for (int i = 0; i < n; i++) begin
      rx_data = reply[39-8*i -: 8];
      rx_rcv  = 1'b1;
      step();
      rx_rcv      = 1'b0;
      last_rx_cyc = cyc;
      if (i == 4) begin
        check("rsp_valid_after_5th", {31'd0, rsp_valid}, 32'd1);
        check("cmd_ready_low_in_done", {31'd0, cmd_ready}, 32'd0);
        step();
        check("cmd_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
      end else begin
        step(2);
      end
    end
  endtask

  initial begin : stimulus
    step(2);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset_tx_start", {31'd0, tx_start}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    step();
    check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // CONST round trip, with the first reply byte on the TX_WAIT->RX handover cycle.
    exp_rsp.push_back('{data: 32'd259, err: 1'b0});
    tgt = tx_seen + 5;
    send_cmd(OP_CONST, 32'd0);
    wait_tx(tgt);
    send_reply(40'h00_00_01_03_00, 5, 1'b1);
    wait_rsp(1);

    // ADDR echo, then check the response word is held.
    exp_rsp.push_back('{data: 32'h12345678, err: 1'b0});
    tgt = tx_seen + 5;
    send_cmd(OP_ADDR, 32'h12345678);
    wait_tx(tgt);
    send_reply(40'h12_34_56_78_00, 5, 1'b0);
    wait_rsp(2);
    step(5);
    check("rsp_data_held", rsp_data, 32'h12345678);

    // Nonzero pad byte flags an error.
    exp_rsp.push_back('{data: 32'hAABBCCDD, err: 1'b1});
    tgt = tx_seen + 5;
    send_cmd(OP_READ, 32'h00000100);
    wait_tx(tgt);
    send_reply(40'hAA_BB_CC_DD_01, 5, 1'b0);
    wait_rsp(3);

    // Reset after the second request byte starts.
    tgt = tx_seen + 2;
    send_cmd(OP_WRITE, 32'hCAFEF00D);
    begin
      int k = 0;
      while (tx_seen < tgt && k < 200) begin
        step();
        k++;
      end
      check("wait_second_byte_bound", {31'd0, k < 200}, 32'd1);
    end
    reset = 1'b1;
    step();
    check("tx_start_in_reset", {31'd0, tx_start}, 32'd0);
    check("cmd_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    exp_tx.delete();
    step();
    check("cmd_ready_post_reset", {31'd0, cmd_ready}, 32'd1);
    check("tx_start_post_reset", {31'd0, tx_start}, 32'd0);
    step(20);
    check("no_rsp_after_reset", rsp_seen, 32'd3);

    exp_rsp.push_back('{data: 32'd259, err: 1'b0});
    tgt = tx_seen + 5;
    send_cmd(OP_CONST, 32'd0);
    wait_tx(tgt);
    send_reply(40'h00_00_01_03_00, 5, 1'b0);
    wait_rsp(4);

    // Back-to-back with cmd_valid held high across both commands.
    push_tx(OP_READ, 32'h00000040);
    push_tx(OP_COUNT, 32'h00000010);
    exp_rsp.push_back('{data: 32'h0BADF00D, err: 1'b0});
    exp_rsp.push_back('{data: 32'h00000010, err: 1'b0});
    wait_ready_idle();
    tgt = tx_seen + 5;
    cmd_op    = OP_READ;
    cmd_data  = 32'h00000040;
    cmd_valid = 1'b1;
    step();
    check("b2b_first_accept", {31'd0, cmd_ready}, 32'd0);
    cmd_op   = OP_COUNT;
    cmd_data = 32'h00000010;
    wait_tx(tgt);
    send_reply(40'h0B_AD_F0_0D_00, 5, 1'b0);
    step();
    check("b2b_second_accept", {31'd0, cmd_ready}, 32'd0);
    check("b2b_second_tx_start", {31'd0, tx_start}, 32'd1);
    check("b2b_second_opcode", {24'd0, tx_data}, {24'd0, OP_COUNT});
    cmd_valid = 1'b0;
    wait_tx(tgt + 5);
    send_reply(40'h00_00_00_10_00, 5, 1'b0);
    wait_rsp(6);

`ifdef CMD_MASTER_TIMEOUT_EN
    // Partial reply then silence: timeout 100 cycles after the last byte.
    exp_rsp.push_back('{data: 32'h00001122, err: 1'b1});
    tgt = tx_seen + 5;
    send_cmd(OP_READ_REQ, 32'd0);
    wait_tx(tgt);
    send_reply(40'h11_22_00_00_00, 2, 1'b0);
    wait_rsp(7);
    check("timeout_latency", rsp_cyc - last_rx_cyc, 32'd100);
`endif

    step(5);
    check("exp_tx_drained", exp_tx.size(), 32'd0);
    check("exp_rsp_drained", exp_rsp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
